// File: rtl/csa_resolve_48bit.sv
// -----------------------------------------------------------------------------
// csa_resolve_48bit
//   Resolves the redundant (sum, carry) pair from the 48-bit carry-save adder
//   into a binary result. The carry-propagate add is split over two registered
//   stages so that each stage's carry chain is about half the word:
//     S1: low  segment  sum_in[SPLIT-1:0] + co_in[SPLIT-1:0]
//     S2: high segment  sum_hi + co_hi + carry from S1
//   Both ends use an elastic valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset, clears valids and data
//   flush      synchronous; empties both stages at the next edge
//   sum_in     CSA sum vector
//   co_in      CSA carry vector (already shifted), added as-is
//   in_valid   input pair valid
//   in_ready   block can take a pair this cycle (no path from in_valid)
//   result     (sum_in + co_in) mod 2^WIDTH
//   carry_out  carry out of bit WIDTH-1
//   out_valid  result/carry_out valid
//   out_ready  consumer takes the result this cycle
// -----------------------------------------------------------------------------
module csa_resolve_48bit #(
   parameter int WIDTH = 48,
   parameter int SPLIT = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] sum_in,
   input  logic [WIDTH-1:0] co_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int HI = WIDTH - SPLIT;

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [SPLIT-1:0] low_q;
   logic             c_mid_q;
   logic [HI-1:0]    sum_hi_q;
   logic [HI-1:0]    co_hi_q;

   // Stage 2 state
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;

   // Handshake
   logic s2_free;
   logic s1_adv;
   logic accept;
   logic out_xfer;

   // Segment adders, one bit wider than their operands to keep the carry
   logic [SPLIT:0] low_sum;
   logic [HI:0]    hi_sum;

   assign s2_free  = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_free;
   assign in_ready = !s1_valid_q || s2_free;
   assign accept   = in_valid && in_ready;
   assign out_xfer = s2_valid_q && out_ready;

   assign low_sum = {1'b0, sum_in[SPLIT-1:0]} + {1'b0, co_in[SPLIT-1:0]};
   assign hi_sum  = {1'b0, sum_hi_q} + {1'b0, co_hi_q} + {{HI{1'b0}}, c_mid_q};

   // Valid bits. Flush overrides any advance or accept in the same cycle.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (accept)
            s1_valid_d = 1'b1;
         else if (s1_adv)
            s1_valid_d = 1'b0;

         // A refill from S1 wins over draining S2 on an output transfer
         if (s1_adv)
            s2_valid_d = 1'b1;
         else if (out_xfer)
            s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   // Data registers only load on a real transfer, so a stalled S2 holds
   // result/carry_out stable for the consumer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         low_q    <= '0;
         c_mid_q  <= 1'b0;
         sum_hi_q <= '0;
         co_hi_q  <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else if (!flush) begin
         if (accept) begin
            low_q    <= low_sum[SPLIT-1:0];
            c_mid_q  <= low_sum[SPLIT];
            sum_hi_q <= sum_in[WIDTH-1:SPLIT];
            co_hi_q  <= co_in[WIDTH-1:SPLIT];
         end
         if (s1_adv) begin
            result_q <= {hi_sum[HI-1:0], low_q};
            carry_q  <= hi_sum[HI];
         end
      end
   end

   assign result    = result_q;
   assign carry_out = carry_q;
   assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_csa_resolve_48bit.sv
module tb_csa_resolve_48bit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic [47:0] sum_in = '0;
   logic [47:0] co_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [47:0] result;
   logic        carry_out;
   logic        out_valid;
   logic        out_ready = 1'b1;

   csa_resolve_48bit #(.WIDTH(48), .SPLIT(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .sum_in    (sum_in),
      .co_in     (co_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .carry_out (carry_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] s;
      logic [47:0] c;
      logic [47:0] r;
      logic        co;
   } vec_t;

   typedef struct packed {
      logic        co;
      logic [47:0] r;
   } exp_t;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int n_out = 0;

   exp_t sb[$];
   int   pop_cyc[$];

   // Expected value for the pair currently being driven
   logic [47:0] drv_r = '0;
   logic        drv_c = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: push on accept, pop/compare on output transfer.
   always @(negedge clk) begin
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_output: got result=%h carry=%b expected no output", result, carry_out);
            end else begin
               exp_t e;
               e = sb.pop_front();
               $display("out %0d: result=%h carry=%b (exp %h/%b)", n_out, result, carry_out, e.r, e.co);
               chk("sb_result", {16'h0, result}, {16'h0, e.r});
               chk("sb_carry", {63'h0, carry_out}, {63'h0, e.co});
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{co: drv_c, r: drv_r});
      end
   end

   function automatic logic [48:0] model(input logic [47:0] s, input logic [47:0] c);
      return {1'b0, s} + {1'b0, c};
   endfunction

   // Drive one pair until accepted; returns the accept cycle.
   task automatic send(input logic [47:0] s, input logic [47:0] c,
                       input logic [47:0] r, input logic co,
                       input bit keep, output int acc_cyc);
      bit ok;
      ok = 0;
      acc_cyc = -1;
      sum_in = s;
      co_in = c;
      drv_r = r;
      drv_c = co;
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         acc_cyc = cyc;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   vec_t tbl[10];
   int   acc[4];
   int   a;
   logic [48:0] m;

   initial begin
      tbl[0] = '{48'h000000FFFFFF, 48'h000000000002, 48'h000001000001, 1'b0};
      tbl[1] = '{48'hFFFFFFFFFFFF, 48'h000000000001, 48'h000000000000, 1'b1};
      tbl[2] = '{48'h800000000000, 48'h800000000000, 48'h000000000000, 1'b1};
      tbl[3] = '{48'h123456789ABC, 48'h111111111111, 48'h23456789ABCD, 1'b0};
      tbl[4] = '{48'h000000000000, 48'h000000000000, 48'h000000000000, 1'b0};
      tbl[5] = '{48'h000000FFFFFF, 48'h000000FFFFFF, 48'h000001FFFFFE, 1'b0};
      tbl[6] = '{48'hFFFFFF000000, 48'h000001000000, 48'h000000000000, 1'b1};
      tbl[7] = '{48'h0000007FFFFF, 48'h000000000001, 48'h000000800000, 1'b0};
      tbl[8] = '{48'hAAAAAAAAAAAA, 48'h555555555555, 48'hFFFFFFFFFFFF, 1'b0};
      tbl[9] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFE, 1'b1};

      // ---- reset state ----
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_result", {16'h0, result}, 64'h0);
      chk("rst_carry", {63'h0, carry_out}, 64'h0);
      chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
      idle(2);
      @(posedge clk);
      #2 rst = 1'b0;
      idle(1);

      // ---- single op: latency and cross-segment carry ----
      send(48'h000000FFFFFF, 48'h000000000002, 48'h000001000001, 1'b0, 0, a);
      @(negedge clk);
      chk("lat_cycle1_out_valid", {63'h0, out_valid}, 64'h0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_out_valid", {63'h0, out_valid}, 64'h1);
      chk("lat_result", {16'h0, result}, 64'h000001000001);
      idle(3);

      // ---- table-driven vectors ----
      for (int i = 0; i < 10; i++) begin
         send(tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].co, 0, a);
         $display("in  vec %0d: sum=%h co=%h", i, tbl[i].s, tbl[i].c);
         idle(i % 3);
      end
      idle(4);
      chk("tbl_drained", sb.size(), 0);

      // ---- back-to-back full throughput ----
      pop_cyc.delete();
      for (int n = 1; n <= 4; n++) begin
         m = model(48'(n), 48'(2 * n));
         send(48'(n), 48'(2 * n), m[47:0], m[48], n < 4, acc[n-1]);
      end
      idle(5);
      chk("b2b_pop_count", pop_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_accept_cycle", acc[i], acc[0] + i);
         if (i < pop_cyc.size())
            chk("b2b_out_cycle", pop_cyc[i], acc[0] + 2 + i);
      end

      // ---- backpressure ----
      out_ready = 1'b0;
      send(48'h000000111111, 48'h000000FFFFFF, 48'h000001111110, 1'b0, 0, a);
      send(48'h222222000000, 48'h000000000005, 48'h222222000005, 1'b0, 0, a);
      sum_in = 48'h0;
      co_in = 48'h0;
      in_valid = 1'b1;
      drv_r = 48'hFFFFFFFFFFFF;
      drv_c = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
         chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
         chk("bp_hold_result", {16'h0, result}, 64'h000001111110);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFE, 1'b1, 0, a);
      idle(5);
      chk("bp_drained", sb.size(), 0);

      // ---- asynchronous reset mid-flight ----
      out_ready = 1'b0;
      send(48'h000000000010, 48'h000000000020, 48'h000000000030, 1'b0, 0, a);
      send(48'h000000000040, 48'h000000000050, 48'h000000000090, 1'b0, 0, a);
      @(negedge clk);
      chk("pre_rst_full_in_ready", {63'h0, in_ready}, 64'h0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
      chk("mid_rst_result", {16'h0, result}, 64'h0);
      chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h1);
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
      end
      idle(1);

      // ---- flush with S2 full and a same-cycle accept ----
      out_ready = 1'b0;
      send(48'h000000000100, 48'h000000000200, 48'h000000000300, 1'b0, 0, a);
      idle(1);
      sum_in = 48'h000000000400;
      co_in = 48'h000000000500;
      drv_r = 48'h000000000900;
      drv_c = 1'b0;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_cycle_in_ready", {63'h0, in_ready}, 64'h1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {63'h0, out_valid}, 64'h0);
      chk("flush_in_ready", {63'h0, in_ready}, 64'h1);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_flush_out_valid", {63'h0, out_valid}, 64'h0);
      end

      // ---- pipeline works after flush ----
      send(48'h0000000FFFFF, 48'h000000F00001, 48'h000001000000, 1'b0, 0, a);
      idle(4);
      chk("final_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/csa_resolve_48bit.md
Name: csa_resolve_48bit

Overview:
Carry-propagate resolver that sits directly downstream of the 48-bit carry-save adder. It takes the CSA's redundant (sum, carry) pair and produces the final binary result.
- The 48-bit add is split into two registered segments (low, then high) so the carry chain fits the target clock.
- Both sides use an elastic valid/ready handshake, so the block can stall without losing data.

Parameters:
- WIDTH, 48, operand/result width in bits.
- SPLIT, 24, width of the low segment added in stage 1. The high segment is WIDTH-SPLIT bits. Legal range is 1 to WIDTH-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; clears both pipeline stages.
- sum_in  input  WIDTH  CSA sum vector.
- co_in  input  WIDTH  CSA carry vector, already shifted left by 1. Added as-is; bit 0 is not assumed to be zero.
- in_valid  input  1  sum_in/co_in hold a valid operand pair.
- in_ready  output  1  block accepts the pair this cycle.
- result  output  WIDTH  sum_in + co_in, modulo 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  result/carry_out are valid.
- out_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst=1, asynchronous): s1_valid=0, s2_valid=0. All data registers are cleared to 0, so result=0, carry_out=0, out_valid=0.
  - in_ready is combinational and equals 1 during and after reset.
  - Reset asserted mid-operation discards all in-flight operands immediately. No partial result is ever presented.
- Stage 1 (S1), loads on accept = in_valid && in_ready:
  - low_sum = sum_in[SPLIT-1:0] + co_in[SPLIT-1:0], computed SPLIT+1 bits wide.
  - Registers low_sum[SPLIT-1:0], c_mid = low_sum[SPLIT], sum_in[WIDTH-1:SPLIT] and co_in[WIDTH-1:SPLIT]; sets s1_valid.
- Stage 2 (S2), loads when S1 advances:
  - hi = sum_hi + co_hi + c_mid, computed WIDTH-SPLIT+1 bits wide.
  - result = {hi[WIDTH-SPLIT-1:0], low_reg}; carry_out = hi[WIDTH-SPLIT]; sets s2_valid.
  - out_valid = s2_valid.
- Handshake and advance logic:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational; there is no path from in_valid to in_ready.
  - An output transfer happens on out_valid && out_ready. If S1 is not advancing on that cycle, s2_valid clears.
  - S1 clears s1_valid when it advances and no new accept happens on the same cycle.
  - Simultaneous accept + S1 advance + output transfer in one cycle is legal and gives full throughput of 1 result per cycle.
- Latency and ordering:
  - Latency is exactly 2 cycles from accept to out_valid when out_ready is held high.
  - Results emerge in acceptance order; none are dropped or duplicated.
- Stall rules:
  - With out_ready=0 and both stages full, in_ready=0.
  - While out_valid=1 and out_ready=0, result and carry_out must hold stable.
- Flush:
  - flush=1 clears s1_valid and s2_valid at the next edge. Data registers may keep stale values.
  - An accept on the same cycle as flush is discarded.
  - flush has priority over every advance.
- Wrap-around: arithmetic is modulo 2^WIDTH, and the overflow bit is reported only through carry_out.

Test Plan:
- Single op, out_ready=1: sum_in=0x000000FFFFFF, co_in=0x000000000002. Expect out_valid 2 cycles after accept, result=0x000001000001, carry_out=0 (exercises the cross-segment carry).
- Full wrap: sum_in=0xFFFFFFFFFFFF, co_in=0x000000000001. Expect result=0x000000000000, carry_out=1.
- Back-to-back: 4 consecutive pairs (n, 2n) for n=1..4 with out_ready=1. Expect in_ready held at 1 and results 3, 6, 9, 12 on 4 consecutive cycles, starting 2 cycles after the first accept.
- Backpressure:
  - Drive 3 pairs with out_ready=0. Expect in_ready=0 after 2 accepts, and the first result held stable.
  - Release out_ready. Expect all 3 results in order with no loss.
- Reset mid-flight: assert rst asynchronously (between clock edges) with S1 and S2 both full. Expect out_valid=0 and result=0 immediately; after release, in_ready=1 and no stale output appears.
- Flush: flush=1 on the same cycle as an accept, with S2 holding a result. Next cycle expect out_valid=0, in_ready=1, and no output for either operand.
